// File: rtl/hpdcache_fifo_ft_pkg.sv
// hpdcache_fifo_ft_pkg: shared helpers for the refill FIFO and its pointer counters.
package hpdcache_fifo_ft_pkg;

    // Pointer width for an N-entry ring; a single-entry ring still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hpdcache_mod_counter.sv
// hpdcache_mod_counter: modulo-N up-counter with enable and synchronous clear.
module hpdcache_mod_counter
    import hpdcache_fifo_ft_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = ptr_width(N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Wrap by compare so that non-power-of-two moduli work.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = (cnt_q == W'(N - 1)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/hpdcache_fifo_ft.sv
// hpdcache_fifo_ft: refill-response FIFO with optional feedthrough, flush,
// arbitrary depth, almost-full flag and occupancy/high-water reporting.
module hpdcache_fifo_ft
    import hpdcache_fifo_ft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter bit          FEEDTHROUGH     = 1'b0,
    parameter int unsigned ALMOST_FULL_THR = FIFO_DEPTH - 1,
    parameter int unsigned USED_WIDTH      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  w_i,
    output logic                  wok_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  r_i,
    output logic                  rok_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [USED_WIDTH-1:0] used_o,
    output logic [USED_WIDTH-1:0] used_max_o,
    output logic                  almost_full_o
);

    localparam int unsigned PW = ptr_width(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [USED_WIDTH-1:0] used_q, used_d, used_max_q, used_max_d;
    logic                  full, empty, push, pop, ft, wr_en, rd_en;

    assign full  = (used_q == USED_WIDTH'(FIFO_DEPTH));
    assign empty = (used_q == '0);

    assign wok_o = !full && !flush_i;
    assign rok_o = (!empty || (FEEDTHROUGH && w_i)) && !flush_i;

    assign push  = w_i && wok_o;
    assign pop   = r_i && rok_o;
    // A push consumed in the same cycle on an empty FIFO never touches storage.
    assign ft    = FEEDTHROUGH && empty && push && pop;
    assign wr_en = push && !ft;
    assign rd_en = pop && !ft;

    assign used_d     = flush_i ? '0 : used_q + USED_WIDTH'(wr_en) - USED_WIDTH'(rd_en);
    assign used_max_d = (used_d > used_max_q) ? used_d : used_max_q;

    hpdcache_mod_counter #(.N(FIFO_DEPTH)) wptr_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .en_i   (wr_en),
        .q_o    (wptr)
    );

    hpdcache_mod_counter #(.N(FIFO_DEPTH)) rptr_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .en_i   (rd_en),
        .q_o    (rptr)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            used_q     <= '0;
            used_max_q <= '0;
        end else begin
            used_q     <= used_d;
            used_max_q <= used_max_d;
        end
    end

    // Payload storage is deliberately left uninitialised on reset and flush.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wptr] <= wdata_i;
    end

    assign rdata_o       = (FEEDTHROUGH && empty) ? wdata_i : mem_q[rptr];
    assign used_o        = used_q;
    assign used_max_o    = used_max_q;
    assign almost_full_o = (used_q >= USED_WIDTH'(ALMOST_FULL_THR));

`ifdef ASSERT_OVERFLOW
    overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_i && full))
        else $warning("write while full ignored");
`endif

endmodule

// File: tb/tb_hpdcache_fifo_ft.sv
// tb_hpdcache_fifo_ft: scoreboard bench for a 5-deep feedthrough FIFO with random traffic.
module tb_hpdcache_fifo_ft;

    localparam int DW    = 16;
    localparam int DEPTH = 5;
    localparam int THR   = 4;
    localparam int UW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          w_i = 1'b0;
    logic          r_i = 1'b0;
    logic [DW-1:0] wdata_i = '0;
    logic          wok_o, rok_o, almost_full_o;
    logic [DW-1:0] rdata_o;
    logic [UW-1:0] used_o, used_max_o;

    int            checks = 0;
    int            errors = 0;
    int            cnt = 0;
    int            mx = 0;
    logic [DW-1:0] sb_q [$];

    hpdcache_fifo_ft #(
        .DATA_WIDTH      (DW),
        .FIFO_DEPTH      (DEPTH),
        .FEEDTHROUGH     (1'b1),
        .ALMOST_FULL_THR (THR)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .w_i           (w_i),
        .wok_o         (wok_o),
        .wdata_i       (wdata_i),
        .r_i           (r_i),
        .rok_o         (rok_o),
        .rdata_o       (rdata_o),
        .used_o        (used_o),
        .used_max_o    (used_max_o),
        .almost_full_o (almost_full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference model is a plain occupancy count plus the data queue.
    task automatic cyc(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
        logic ew, er, ep, eq;
        @(posedge clk_i);
        #1;
        w_i = w; r_i = r; flush_i = f; wdata_i = d;
        #1;
        ew = (cnt < DEPTH) && !f;
        er = (cnt > 0 || w) && !f;
        chk("wok", wok_o, ew);
        chk("rok", rok_o, er);
        chk("used", used_o, cnt);
        chk("used_max", used_max_o, mx);
        chk("almost_full", almost_full_o, cnt >= THR);
        if (f) begin
            cnt = 0;
            sb_q.delete();
        end else begin
            ep = w && ew;
            eq = r && er;
            if (ep) sb_q.push_back(d);
            if (!(ep && eq && cnt == 0)) cnt = cnt + int'(ep) - int'(eq);
        end
        if (cnt > mx) mx = cnt;
    endtask

    task automatic reset_checks();
        chk("rst_wok", wok_o, 1);
        chk("rst_rok", rok_o, 0);
        chk("rst_used", used_o, 0);
        chk("rst_used_max", used_max_o, 0);
        chk("rst_almost_full", almost_full_o, 0);
        cnt = 0;
        mx = 0;
        sb_q.delete();
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++)
            cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                $urandom_range(0, 99) < 2, DW'($urandom));
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (rst_ni && r_i && rok_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata: got %0h with scoreboard empty at %0t", rdata_o, $time);
                end else begin
                    chk("rdata", rdata_o, sb_q.pop_front());
                end
            end
        end
    end

    initial begin : driver
        #3;
        reset_checks();
        #20;
        rst_ni = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 16'h0055);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, DW'(16'hA0 + i));
        cyc(1'b1, 1'b1, 1'b0, 16'h00F0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b1, 16'h0077);
        cyc(1'b0, 1'b0, 1'b0, '0);
        rand_phase(1500);
        cyc(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, DW'(16'hC0 + i));
        @(posedge clk_i);
        #1;
        w_i = 1'b0; r_i = 1'b0; flush_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        reset_checks();
        repeat (2) @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 16'h1234);
        cyc(1'b1, 1'b0, 1'b0, 16'h5678);
        cyc(1'b0, 1'b1, 1'b0, '0);
        rand_phase(500);
        for (int i = 0; i < 2 * DEPTH && cnt > 0; i++) cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk_i);
        #1;
        chk("drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hpdcache_fifo_ft.md
# hpdcache_fifo_ft

Parametrised synchronous FIFO with an optional combinational feedthrough path, non-power-of-two depth, synchronous flush, an almost-full flag and occupancy/high-water reporting. It buffers refill responses between the HPDcache refill handler and the core response arbiter. Its `FIFO_DEPTH` and `FEEDTHROUGH` parameters are driven from `hpdcache_params_pkg::PARAM_REFILL_FIFO_DEPTH` and `PARAM_REFILL_CORE_RSP_FEEDTHROUGH`. This makes the refill-FIFO depth formula `MSHR_SETS*MSHR_WAYS+10` legal, which the previous power-of-two-only FIFO did not support.

## Interface
Parameters:
- `DATA_WIDTH`, 64: payload width in bits.
- `FIFO_DEPTH`, 2: number of entries; any integer ≥ 1, not restricted to powers of two.
- `FEEDTHROUGH`, 1'b0: when 1, write data passes to the read port in the same cycle while the FIFO is empty.
- `ALMOST_FULL_THR`, `FIFO_DEPTH-1`: `almost_full_o` asserts when occupancy ≥ this value; range 1..`FIFO_DEPTH`.
- `USED_WIDTH`, `$clog2(FIFO_DEPTH+1)`: derived; do not override.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset; asynchronous and active-low.
- `flush_i`  in  1  synchronous clear of all entries.
- `w_i`  in  1  write request.
- `wok_o`  out  1  write accepted (not full).
- `wdata_i`  in  `DATA_WIDTH`  write payload.
- `r_i`  in  1  read request (consumer ready).
- `rok_o`  out  1  read data valid.
- `rdata_o`  out  `DATA_WIDTH`  read payload.
- `used_o`  out  `USED_WIDTH`  current occupancy, 0..`FIFO_DEPTH`.
- `used_max_o`  out  `USED_WIDTH`  high-water mark of `used_o` since reset.
- `almost_full_o`  out  1  `used_o` ≥ `ALMOST_FULL_THR`.

## Operation
Storage and pointers:
- Storage is a circular register array, `mem[FIFO_DEPTH]`.
- `wptr` and `rptr` range over 0..`FIFO_DEPTH-1`. Each wraps explicitly from `FIFO_DEPTH-1` to 0 with a compare, never by bit truncation.
- `used` counts 0..`FIFO_DEPTH`. `full` = (`used`==`FIFO_DEPTH`); `empty` = (`used`==0).

Handshake outputs:
- `wok_o` = !`full` & !`flush_i`. It does not depend on `r_i`, so there is no combinational ready path.
- `rok_o` = (!`empty` | (`FEEDTHROUGH` & `w_i`)) & !`flush_i`.
- `rdata_o` = `wdata_i` when `FEEDTHROUGH` & `empty`; otherwise `mem[rptr]`.

Transfers:
- Push = `w_i` & `wok_o`. Pop = `r_i` & `rok_o`.
- Feedthrough transfer: `empty` & push & pop. No storage write, pointers and `used` unchanged.
- Push only: `mem[wptr]`←`wdata_i`, `wptr`++, `used`++.
- Pop only: `rptr`++, `used`--.
- Push and pop when not empty: both pointers advance, `used` unchanged. This remains legal at `used`==`FIFO_DEPTH-1`.
- Write while full: ignored. Read while empty without feedthrough: ignored. Simulation assertions fire on `w_i`&`full` only when an `ASSERT_OVERFLOW` define is set; they are informational.

Flush and status:
- `flush_i` has priority over push and pop in the same cycle. Next state: `wptr`=`rptr`=0, `used`=0.
- `mem` contents are not cleared by flush or reset.
- `used_max` updates to `max(used_max, used_next)` every cycle. It is cleared only by reset, not by flush.

## Timing
- Write-to-read latency is 1 cycle through storage, or 0 cycles via feedthrough when `empty`.
- All state registers reset asynchronously on `rst_ni`=0: `wptr`=`rptr`=0, `used`=0, `used_max`=0.
- Output values during and immediately after reset: `wok_o`=1, `rok_o`=0 (with `w_i`=0, or `FEEDTHROUGH`=0), `used_o`=0, `used_max_o`=0, `almost_full_o`=0.
- Reset asserted mid-operation drops all entries immediately; there is no drain.
- `used_o`, `used_max_o` and `almost_full_o` reflect registered state. They are valid one cycle after the causing push or pop. Feedthrough transfers never change them.
- `FIFO_DEPTH`=1 is legal: `wok_o` deasserts after one push. Back-to-back single-entry streaming requires push and pop in the same cycle while full, which is not allowed, so throughput is 1/2 unless `FEEDTHROUGH`=1.

## Structure
- No new typedefs in `hpdcache_pkg`. Payload is a flat vector; instantiators cast their struct type.
- Depth and feedthrough are bound at instantiation from `hpdcache_params_pkg`.
- One sub-module: `hpdcache_mod_counter`, a modulo-N up-counter with enable and synchronous clear. It is instantiated twice, for `wptr` and `rptr`.

## Test plan
- `FIFO_DEPTH`=3, `FEEDTHROUGH`=0: push A,B,C → `wok_o`=0, `used_o`=3, `almost_full_o`=1; pop three times → A,B,C in order, `used_max_o`=3.
- `FIFO_DEPTH`=5: 12 pushes interleaved with pops, so pointers wrap twice → output order is preserved, no loss.
- `FEEDTHROUGH`=1, empty, `w_i`=`r_i`=1 with `wdata_i`=0x55 → `rok_o`=1 and `rdata_o`=0x55 in the same cycle; `used_o` stays 0.
- Full FIFO with `w_i`=`r_i`=1 → head is popped, no write; `used_o`=`FIFO_DEPTH-1` next cycle.
- `used_o`=2 and `flush_i` asserted together with `w_i`,`r_i` → next cycle `used_o`=0, no transfer; `used_max_o` keeps 2.
- `rst_ni` pulled low mid-stream with `used_o`=4 → outputs return to their reset values asynchronously, and the first pushed datum after release is the first read.
